// File: rtl/word_serializer.sv
// Parallel-to-serial converter: captures a word on Start, shifts it out one bit per clock,
// optionally follows it with an even-parity bit, then pulses Done for one cycle.
module word_serializer #(
    parameter int unsigned WIDTH     = 32,
    parameter bit          MSB_FIRST = 1'b1,
    parameter bit          PARITY_EN = 1'b0
) (
    input  logic                          Clk,
    input  logic                          Reset,
    input  logic [WIDTH-1:0]              Data_in,
    input  logic                          Start,
    output logic                          Ready,
    output logic                          Busy,
    output logic                          Serial_out,
    output logic                          Done,
    output logic [$clog2(WIDTH+2)-1:0]    Bit_count
);

    localparam int unsigned CW = $clog2(WIDTH + 2);
    localparam logic [CW-1:0] LastCnt = CW'(WIDTH);
    localparam logic [CW-1:0] OneCnt  = CW'(1);

    typedef enum logic [1:0] {StIdle, StShift, StPar, StDone} state_e;

    state_e             state_q, state_d;
    logic [WIDTH-1:0]   shreg_q, shreg_d;
    logic [CW-1:0]      cnt_q, cnt_d;
    logic               ser_q, ser_d;
    logic               done_q, done_d;
    logic               ready_q, ready_d;
    logic               busy_q, busy_d;
    logic               par_q, par_d;

    always_comb begin
        state_d = state_q;
        shreg_d = shreg_q;
        cnt_d   = cnt_q;
        ser_d   = ser_q;
        done_d  = 1'b0;
        par_d   = par_q;

        case (state_q)
            StIdle: begin
                if (Start) begin
                    // First bit goes straight to the output; the register keeps the rest queued.
                    ser_d   = MSB_FIRST ? Data_in[WIDTH-1] : Data_in[0];
                    shreg_d = MSB_FIRST ? (Data_in << 1) : (Data_in >> 1);
                    par_d   = ^Data_in;
                    cnt_d   = OneCnt;
                    state_d = StShift;
                end
            end
            StShift: begin
                if (cnt_q == LastCnt) begin
                    if (PARITY_EN) begin
                        ser_d   = par_q;
                        cnt_d   = cnt_q + OneCnt;
                        state_d = StPar;
                    end else begin
                        ser_d   = 1'b0;
                        cnt_d   = '0;
                        done_d  = 1'b1;
                        state_d = StDone;
                    end
                end else begin
                    ser_d   = MSB_FIRST ? shreg_q[WIDTH-1] : shreg_q[0];
                    shreg_d = MSB_FIRST ? (shreg_q << 1) : (shreg_q >> 1);
                    cnt_d   = cnt_q + OneCnt;
                end
            end
            StPar: begin
                ser_d   = 1'b0;
                cnt_d   = '0;
                done_d  = 1'b1;
                state_d = StDone;
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase

        ready_d = (state_d == StIdle);
        busy_d  = (state_d == StShift) || (state_d == StPar);
    end

    always_ff @(posedge Clk) begin
        if (!Reset) begin
            state_q <= StIdle;
            shreg_q <= '0;
            cnt_q   <= '0;
            ser_q   <= 1'b0;
            done_q  <= 1'b0;
            ready_q <= 1'b1;
            busy_q  <= 1'b0;
            par_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            shreg_q <= shreg_d;
            cnt_q   <= cnt_d;
            ser_q   <= ser_d;
            done_q  <= done_d;
            ready_q <= ready_d;
            busy_q  <= busy_d;
            par_q   <= par_d;
        end
    end

    assign Ready      = ready_q;
    assign Busy       = busy_q;
    assign Serial_out = ser_q;
    assign Done       = done_q;
    assign Bit_count  = cnt_q;

endmodule

// File: tb/tb_word_serializer.sv
// Directed bench for word_serializer: one default instance (MSB first, no parity) and one
// LSB-first instance with parity, checked bit by bit against the driven words.
module tb_word_serializer;

    logic        Clk = 1'b0;
    logic        Reset;
    logic [31:0] din0, din1;
    logic        st0, st1;
    logic        rdy0, rdy1, bsy0, bsy1, ser0, ser1, dn0, dn1;
    logic [5:0]  bc0, bc1;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 Clk = ~Clk;

    word_serializer dut0 (
        .Clk        (Clk),
        .Reset      (Reset),
        .Data_in    (din0),
        .Start      (st0),
        .Ready      (rdy0),
        .Busy       (bsy0),
        .Serial_out (ser0),
        .Done       (dn0),
        .Bit_count  (bc0)
    );

    word_serializer #(
        .WIDTH     (32),
        .MSB_FIRST (1'b0),
        .PARITY_EN (1'b1)
    ) dut1 (
        .Clk        (Clk),
        .Reset      (Reset),
        .Data_in    (din1),
        .Start      (st1),
        .Ready      (rdy1),
        .Busy       (bsy1),
        .Serial_out (ser1),
        .Done       (dn1),
        .Bit_count  (bc1)
    );

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    // Checks all outputs of instance s against the expected values.
    task automatic check_outs(input int s, input string tag, input logic rdy, input logic bsy,
                              input logic ser, input logic dn, input logic [5:0] bc);
        check_eq({tag, ".ready"},  (s == 0) ? rdy0 : rdy1, rdy);
        check_eq({tag, ".busy"},   (s == 0) ? bsy0 : bsy1, bsy);
        check_eq({tag, ".serial"}, (s == 0) ? ser0 : ser1, ser);
        check_eq({tag, ".done"},   (s == 0) ? dn0  : dn1,  dn);
        check_eq({tag, ".count"},  (s == 0) ? bc0  : bc1,  bc);
    endtask

    task automatic set_data(input int s, input logic [31:0] w);
        if (s == 0) din0 = w; else din1 = w;
    endtask

    // Called just after the capture edge; walks the frame through Done and back to idle.
    // If mut_at >= 0, Data_in is changed to mut after that many bits have been checked.
    task automatic stream(input int s, input string tag, input logic [31:0] w, input bit msb,
                          input bit par, input int mut_at, input logic [31:0] mut);
        for (int k = 0; k < 32; k++) begin
            check_outs(s, $sformatf("%s.bit%0d", tag, k), 1'b0, 1'b1,
                       msb ? w[31-k] : w[k], 1'b0, 6'(k + 1));
            if (k == mut_at) set_data(s, mut);
            tick();
        end
        if (par) begin
            check_outs(s, {tag, ".parity"}, 1'b0, 1'b1, ^w, 1'b0, 6'd33);
            tick();
        end
        check_outs(s, {tag, ".done"}, 1'b0, 1'b0, 1'b0, 1'b1, 6'd0);
        tick();
        check_outs(s, {tag, ".idle"}, 1'b1, 1'b0, 1'b0, 1'b0, 6'd0);
    endtask

    task automatic frame(input int s, input string tag, input logic [31:0] w, input bit msb,
                         input bit par, input int mut_at, input logic [31:0] mut);
        set_data(s, w);
        if (s == 0) st0 = 1'b1; else st1 = 1'b1;
        tick();
        if (s == 0) st0 = 1'b0; else st1 = 1'b0;
        stream(s, tag, w, msb, par, mut_at, mut);
    endtask

    initial begin
        Reset = 1'b0;
        st0 = 1'b1;  // reset must win over Start
        st1 = 1'b1;
        din0 = 32'hDEADBEEF;
        din1 = 32'hDEADBEEF;
        tick();
        tick();
        check_outs(0, "rst_vs_start0", 1'b1, 1'b0, 1'b0, 1'b0, 6'd0);
        check_outs(1, "rst_vs_start1", 1'b1, 1'b0, 1'b0, 1'b0, 6'd0);
        Reset = 1'b1;
        st0 = 1'b0;
        st1 = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick();
            check_outs(0, $sformatf("idle0_%0d", i), 1'b1, 1'b0, 1'b0, 1'b0, 6'd0);
            check_outs(1, $sformatf("idle1_%0d", i), 1'b1, 1'b0, 1'b0, 1'b0, 6'd0);
        end

        frame(0, "alt_msb", 32'h55555555, 1'b1, 1'b0, -1, 32'h0);
        frame(1, "lsb_par", 32'hFFFF0000, 1'b0, 1'b1, -1, 32'h0);
        frame(1, "par_one", 32'h00000001, 1'b0, 1'b1, 7, 32'hFFFFFFFF);

        // Abort: Start and Reset together at the tenth edge of a frame.
        set_data(0, 32'hCAFEF00D);
        st0 = 1'b1;
        tick();
        st0 = 1'b0;
        for (int i = 0; i < 9; i++) tick();
        check_eq("abort.pre_busy", bsy0, 1'b1);
        check_eq("abort.pre_count", bc0, 6'd10);
        Reset = 1'b0;
        st0 = 1'b1;
        tick();
        check_outs(0, "abort", 1'b1, 1'b0, 1'b0, 1'b0, 6'd0);
        Reset = 1'b1;
        st0 = 1'b0;
        for (int i = 0; i < 40; i++) begin
            tick();
            check_eq("abort.no_done", dn0, 1'b0);
        end
        frame(0, "after_abort", 32'h8000_0001, 1'b1, 1'b0, -1, 32'h0);

        // Start held across two frames; data changes mid-frame must not leak in.
        set_data(0, 32'hA5A5A5A5);
        st0 = 1'b1;
        tick();
        stream(0, "b2b_a", 32'hA5A5A5A5, 1'b1, 1'b0, 3, 32'h0000FFFF);
        tick();
        stream(0, "b2b_b", 32'h0000FFFF, 1'b1, 1'b0, -1, 32'h0);
        st0 = 1'b0;
        tick();
        check_outs(0, "b2b_end", 1'b1, 1'b0, 1'b0, 1'b0, 6'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
